// File: rtl/klotski_pkg.sv
// Shared types for the Klotski board path: grid layout, assembler states and error codes.
package klotski_pkg;

  typedef logic [3:0][3:0][3:0] klotski_t;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_ERR
  } asm_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DUP     = 2'd1;
  localparam logic [1:0] ERR_UNSOLV  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/klotski_inv_counter.sv
// Counts the tiles already seen that are larger than v, i.e. the inversions a new tile v adds.
module klotski_inv_counter (
  input  logic [15:0] i_bitmap,
  input  logic [3:0]  i_v,
  output logic [4:0]  o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int j = 0; j < 16; j++) begin
      if ((j > int'(i_v)) && i_bitmap[j]) o_cnt = o_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/klotski_grid_assembler.sv
// Collects 16 row-major tiles, validates permutation and solvability, then issues the grid
// to the top controller and holds it until the controller reports done.
module klotski_grid_assembler
  import klotski_pkg::*;
#(
  parameter int CHECK_SOLVABLE = 1,
  parameter int WAIT_TIMEOUT   = 0
) (
  input  logic       i_Clk,
  input  logic       i_rst,
  input  logic       i_frame_start,
  input  logic       i_cell_valid,
  input  logic [3:0] i_cell_value,
  output logic       o_cell_ready,
  input  logic       i_ctrl_done,
  output klotski_t   o_klotski,
  output logic       o_en,
  output logic       o_busy,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic [6:0] o_inv_count
);

  asm_state_t r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [15:0] r_bitmap;
  logic [6:0]  r_inv;
  logic [1:0]  r_blank_row;
  klotski_t    r_grid;
  logic [1:0]  r_err_code;
  logic [15:0] r_wait_cnt;

  logic       w_accept, w_dup, w_solvable, w_timeout;
  logic       w_clear, w_err_load;
  logic [1:0] w_err_code_nxt;
  logic [4:0] w_pop;

  klotski_inv_counter u_inv (
    .i_bitmap (r_bitmap),
    .i_v      (i_cell_value),
    .o_cnt    (w_pop)
  );

  assign w_accept   = (r_state == S_COLLECT) && i_cell_valid && !i_frame_start;
  assign w_dup      = r_bitmap[i_cell_value];
  // Inversion parity XOR blank row parity: odd means reachable from the solved board.
  assign w_solvable = r_inv[0] ^ r_blank_row[0];
  assign w_timeout  = (WAIT_TIMEOUT > 0) && (r_wait_cnt == 16'(WAIT_TIMEOUT - 1));

  always_ff @(posedge i_Clk) begin
    if (i_rst) r_state <= S_COLLECT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clear        = 1'b0;
    w_err_load     = 1'b0;
    w_err_code_nxt = ERR_NONE;
    case (r_state)
      S_COLLECT: begin
        if (i_frame_start) begin
          w_clear = 1'b1;
        end else if (i_cell_valid) begin
          if (w_dup) begin
            w_state_nxt    = S_ERR;
            w_err_load     = 1'b1;
            w_err_code_nxt = ERR_DUP;
          end else if (r_cnt == 5'd15) begin
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (w_solvable || (CHECK_SOLVABLE == 0)) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt    = S_ERR;
          w_err_load     = 1'b1;
          w_err_code_nxt = ERR_UNSOLV;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_ctrl_done) begin
          w_state_nxt = S_COLLECT;
          w_clear     = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt    = S_ERR;
          w_err_load     = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
        end
      end
      S_ERR: begin
        if (i_frame_start) begin
          w_state_nxt    = S_COLLECT;
          w_clear        = 1'b1;
          w_err_load     = 1'b1;
          w_err_code_nxt = ERR_NONE;
        end
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_bitmap    <= '0;
      r_inv       <= '0;
      r_blank_row <= '0;
      r_grid      <= '0;
      r_err_code  <= ERR_NONE;
      r_wait_cnt  <= '0;
    end else begin
      if (w_clear) begin
        r_cnt       <= '0;
        r_bitmap    <= '0;
        r_inv       <= '0;
        r_blank_row <= '0;
      end else if (w_accept) begin
        r_grid[r_cnt[3:2]][r_cnt[1:0]] <= i_cell_value;
        // A duplicate lands in the grid for debug but does not advance the board.
        if (!w_dup) begin
          r_bitmap[i_cell_value] <= 1'b1;
          r_cnt                  <= r_cnt + 5'd1;
          if (i_cell_value == 4'd0) r_blank_row <= r_cnt[3:2];
          else                      r_inv       <= r_inv + {2'b00, w_pop};
        end
      end
      if ((r_state == S_ERR) && i_frame_start) r_grid <= '0;
      if (w_err_load) r_err_code <= w_err_code_nxt;
      if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 16'd1;
      else                   r_wait_cnt <= '0;
    end
  end

  assign o_cell_ready = (r_state == S_COLLECT);
  assign o_en         = (r_state == S_ISSUE);
  assign o_busy       = (r_state == S_CHECK) || (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign o_err        = (r_state == S_ERR);
  assign o_err_code   = r_err_code;
  assign o_inv_count  = r_inv;
  assign o_klotski    = r_grid;

endmodule

// File: tb/tb_klotski_grid_assembler.sv
// Randomized bench: boards streamed with gaps, checked against a pairwise-inversion reference model.
module tb_klotski_grid_assembler;
  import klotski_pkg::*;

  typedef int board_t [16];

  logic       clk = 1'b0;
  logic       rst, fs, cv, done;
  logic [3:0] cval;
  logic       rdy, en, busy, err;
  logic [1:0] ecode;
  logic [6:0] inv;
  klotski_t   grid;

  logic       b_rst, b_fs, b_done;
  logic       b_rdy, b_en, b_busy, b_err;
  logic [1:0] b_ecode;
  logic [6:0] b_inv;
  klotski_t   b_grid;

  int n_chk = 0, n_fail = 0, en_seen = 0, b_en_seen = 0;

  always #5 clk = ~clk;

  klotski_grid_assembler #(.CHECK_SOLVABLE(1), .WAIT_TIMEOUT(20)) dut (
    .i_Clk(clk), .i_rst(rst), .i_frame_start(fs), .i_cell_valid(cv), .i_cell_value(cval),
    .o_cell_ready(rdy), .i_ctrl_done(done), .o_klotski(grid), .o_en(en), .o_busy(busy),
    .o_err(err), .o_err_code(ecode), .o_inv_count(inv)
  );

  klotski_grid_assembler #(.CHECK_SOLVABLE(0), .WAIT_TIMEOUT(0)) dut_nochk (
    .i_Clk(clk), .i_rst(b_rst), .i_frame_start(b_fs), .i_cell_valid(cv), .i_cell_value(cval),
    .o_cell_ready(b_rdy), .i_ctrl_done(b_done), .o_klotski(b_grid), .o_en(b_en), .o_busy(b_busy),
    .o_err(b_err), .o_err_code(b_ecode), .o_inv_count(b_inv)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (en) en_seen++;
    if (b_en) b_en_seen++;
  endtask

  // Reference: first repeated value, pairwise inversions of the accepted prefix, blank row.
  task automatic model(input board_t b, output int dup, output int ninv, output int brow,
                       output bit solv);
    bit seen [16];
    int lim;
    for (int k = 0; k < 16; k++) seen[k] = 1'b0;
    dup = -1;
    for (int k = 0; k < 16; k++) begin
      if (seen[b[k]]) begin
        dup = k;
        break;
      end
      seen[b[k]] = 1'b1;
    end
    lim  = (dup < 0) ? 16 : dup;
    ninv = 0;
    brow = 0;
    for (int i = 0; i < lim; i++) begin
      if (b[i] == 0) brow = i / 4;
      for (int j = i + 1; j < lim; j++)
        if (b[i] != 0 && b[j] != 0 && b[i] > b[j]) ninv++;
    end
    solv = ((ninv + brow) % 2) == 1;
  endtask

  function automatic klotski_t to_grid(input board_t b);
    klotski_t g;
    for (int k = 0; k < 16; k++) g[k / 4][k % 4] = b[k][3:0];
    return g;
  endfunction

  task automatic send_cells(input board_t b, input int n, input int gap_max);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      cv   = 1'b1;
      cval = b[k][3:0];
      tick();
      cv   = 1'b0;
    end
  endtask

  task automatic recover(input string tag);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    chk({tag, "/rec_ready"}, rdy, 1);
    chk({tag, "/rec_err"}, err, 0);
    chk({tag, "/rec_code"}, ecode, 0);
    chk({tag, "/rec_inv"}, inv, 0);
  endtask

  task automatic run_board(input board_t b, input int gap_max, input int done_dly, input string tag);
    int  dup, ninv, brow, e0;
    bit  solv;
    model(b, dup, ninv, brow, solv);
    e0 = en_seen;
    if (dup >= 0) begin
      send_cells(b, dup + 1, gap_max);
      chk({tag, "/dup_err"}, err, 1);
      chk({tag, "/dup_code"}, ecode, ERR_DUP);
      chk({tag, "/dup_ready"}, rdy, 0);
      chk({tag, "/dup_inv"}, inv, ninv);
      recover(tag);
    end else begin
      send_cells(b, 16, gap_max);
      chk({tag, "/chk_en"}, en, 0);
      chk({tag, "/chk_busy"}, busy, 1);
      chk({tag, "/inv"}, inv, ninv);
      tick();
      if (solv) begin
        chk({tag, "/en"}, en, 1);
        chk({tag, "/grid"}, grid, to_grid(b));
        repeat (done_dly) tick();
        chk({tag, "/en_once"}, en_seen - e0, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk({tag, "/busy_off"}, busy, 0);
        chk({tag, "/ready_on"}, rdy, 1);
        chk({tag, "/grid_kept"}, grid, to_grid(b));
      end else begin
        chk({tag, "/unsolv_err"}, err, 1);
        chk({tag, "/unsolv_code"}, ecode, ERR_UNSOLV);
        chk({tag, "/unsolv_no_en"}, en_seen - e0, 0);
        recover(tag);
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    board_t solved, unsolv, dupb, rb;
    int w, e0, tmp, j;

    for (int k = 0; k < 15; k++) solved[k] = k + 1;
    solved[15] = 0;
    unsolv = solved;
    unsolv[13] = 15;
    unsolv[14] = 14;
    dupb = '{1, 2, 3, 5, 4, 6, 7, 5, 8, 9, 10, 11, 12, 13, 14, 0};

    rst = 1'b1; fs = 1'b0; cv = 1'b0; cval = '0; done = 1'b0;
    b_rst = 1'b1; b_fs = 1'b0; b_done = 1'b0;
    tick();
    tick();
    chk("rst/ready", rdy, 1);
    chk("rst/en", en, 0);
    chk("rst/busy", busy, 0);
    chk("rst/err", err, 0);
    chk("rst/code", ecode, 0);
    chk("rst/inv", inv, 0);
    chk("rst/grid", grid, 0);
    rst = 1'b0;
    tick();

    run_board(solved, 0, 5, "solved");
    chk("solved/blank_cell", grid[3][3], 0);
    chk("solved/err", err, 0);

    b_rst = 1'b0;
    b_en_seen = 0;
    tick();
    run_board(unsolv, 0, 0, "unsolv");
    chk("nochk/en", b_en_seen, 1);
    chk("nochk/grid", b_grid, to_grid(unsolv));
    chk("nochk/inv", b_inv, 1);
    b_rst = 1'b1;

    run_board(dupb, 0, 0, "dup");

    rb = solved;
    send_cells(rb, 9, 1);
    fs = 1'b1;
    cv = 1'b1;
    cval = 4'd9;
    tick();
    fs = 1'b0;
    cv = 1'b0;
    chk("restart/inv", inv, 0);
    run_board(solved, 1, 3, "restart");

    e0 = en_seen;
    send_cells(solved, 16, 0);
    tick();
    chk("tmo/en", en, 1);
    w = 0;
    while (!err && w < 100) begin
      tick();
      if (busy && !err) w++;
    end
    chk("tmo/wait_cycles", w, 20);
    chk("tmo/code", ecode, ERR_TIMEOUT);
    chk("tmo/en_once", en_seen - e0, 1);
    recover("tmo");

    send_cells(solved, 6, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst/ready", rdy, 1);
    chk("midrst/busy", busy, 0);
    chk("midrst/err", err, 0);
    chk("midrst/code", ecode, 0);
    chk("midrst/inv", inv, 0);
    chk("midrst/grid", grid, 0);
    run_board(solved, 0, 2, "midrst");

    for (int it = 0; it < 14; it++) begin
      for (int k = 0; k < 16; k++) rb[k] = k;
      for (int k = 15; k > 0; k--) begin
        j = $urandom_range(k, 0);
        tmp = rb[k];
        rb[k] = rb[j];
        rb[j] = tmp;
      end
      if ($urandom_range(3, 0) == 0) rb[$urandom_range(15, 0)] = rb[$urandom_range(15, 0)];
      run_board(rb, 3, $urandom_range(15, 0), $sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
